// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
//
// Purpose: shares the 32-bit seven-segment display word between the PCIe
// host path and the local front-panel path. One owner holds the display at a
// time. Each grant is kept for at least HOLD_CYCLES cycles after the owner's
// last accepted write. Round-robin decides a simultaneous request from IDLE.
// When the hold expires, a waiting non-owner beats a re-writing owner. The
// lock input freezes the current owner and its hold counter.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   host_req   host write request, held with host_data stable until host_ack
//   host_data  host display word
//   host_ack   one-cycle pulse: host_data was latched
//   loc_req    local write request, same handshake as host_req
//   loc_data   local display word
//   loc_ack    one-cycle pulse: loc_data was latched
//   lock       level; freezes the current owner and the hold counter
//   disp_data  registered word driving the HEX decoders
//   disp_owner 00 none, 01 host, 10 local (the state register itself)
//   busy       high whenever disp_owner is not 00
module hex_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic [31:0] host_data,
  output logic        host_ack,
  input  logic        loc_req,
  input  logic [31:0] loc_data,
  output logic        loc_ack,
  input  logic        lock,
  output logic [31:0] disp_data,
  output logic [1:0]  disp_owner,
  output logic        busy
);

  // The encoding is the disp_owner value, so the output needs no decode.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OWN_HOST = 2'b01,
    OWN_LOC  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             prefLoc_q, prefLoc_d;
  logic             hostAck_q, locAck_q;

  logic             hostValid, locValid, holdDone;
  logic             grantHost, grantLoc;

  // Next-state logic. A request is masked while its own ack is high. In that
  // cycle the requester still holds req for the transfer just latched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    prefLoc_d = prefLoc_q;
    grantHost = 1'b0;
    grantLoc  = 1'b0;
    hostValid = host_req & ~hostAck_q;
    locValid  = loc_req & ~locAck_q;
    holdDone  = (cnt_q == '0) && !lock;

    case (state_q)
      IDLE: begin
        if (hostValid && locValid) begin
          if (prefLoc_q) grantLoc = 1'b1;
          else           grantHost = 1'b1;
        end else if (hostValid) begin
          grantHost = 1'b1;
        end else if (locValid) begin
          grantLoc = 1'b1;
        end
      end
      OWN_HOST: begin
        if (holdDone && locValid) begin
          grantLoc = 1'b1;
        end else if (hostValid) begin
          grantHost = 1'b1;
        end else if (holdDone) begin
          state_d = IDLE;
        end else if (!lock && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OWN_LOC: begin
        if (holdDone && hostValid) begin
          grantHost = 1'b1;
        end else if (locValid) begin
          grantLoc = 1'b1;
        end else if (holdDone) begin
          state_d = IDLE;
        end else if (!lock && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every grant latches data and restarts the hold.
    // The round-robin pointer then prefers the side that was not just served.
    if (grantHost) begin
      state_d   = OWN_HOST;
      data_d    = host_data;
      cnt_d     = RELOAD;
      prefLoc_d = 1'b1;
    end else if (grantLoc) begin
      state_d   = OWN_LOC;
      data_d    = loc_data;
      cnt_d     = RELOAD;
      prefLoc_d = 1'b0;
    end
  end

  // State, display and ack registers; reset also drops any ack in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      prefLoc_q <= 1'b0;
      hostAck_q <= 1'b0;
      locAck_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      prefLoc_q <= prefLoc_d;
      hostAck_q <= grantHost;
      locAck_q  <= grantLoc;
    end
  end

  assign host_ack   = hostAck_q;
  assign loc_ack    = locAck_q;
  assign disp_data  = data_q;
  assign disp_owner = state_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter
//
// Purpose: drives hex_display_arbiter with directed scenarios and then with
// random requests, lock and reset. A reference model runs on posedge and
// pushes each expected grant into a scoreboard queue. Directed scenarios
// push hand-derived expectations tagged with a cycle number. A monitor on
// negedge compares the DUT against the model and drains both queues.
module tb_hex_display_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req, loc_req, lock;
  logic [31:0] host_data, loc_data;
  logic        host_ack, loc_ack, busy;
  logic [31:0] disp_data;
  logic [1:0]  disp_owner;

  typedef struct {
    int          who;
    logic [31:0] data;
  } sbItem_t;

  typedef struct {
    int          cyc;
    logic [1:0]  owner;
    logic        ha;
    logic        la;
    logic [31:0] data;
  } dirItem_t;

  sbItem_t  sbQ[$];
  dirItem_t dirQ[$];

  int          nChecks = 0;
  int          nFails = 0;
  int          cycleCount = 0;
  bit          testDone = 1'b0;
  bit          finalDone = 1'b0;

  int          mOwner = 0;
  logic [31:0] mData = '0;
  bit          mAckH = 1'b0;
  bit          mAckL = 1'b0;
  int          mElapsed = 0;
  bit          mPrefLoc = 1'b0;

  always #5 clk = ~clk;

  hex_display_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_req   (host_req),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .loc_req    (loc_req),
    .loc_data   (loc_data),
    .loc_ack    (loc_ack),
    .lock       (lock),
    .disp_data  (disp_data),
    .disp_owner (disp_owner),
    .busy       (busy)
  );

  // Reference model. It tracks who owns the display and how many unlocked
  // cycles have passed since the owner's last accepted write. The hold ends
  // once that count reaches HOLD-1 and lock is low.
  initial begin
    int  grant;
    bit  hv, lv, ownReq, otherReq, holdDone;
    forever begin
      @(posedge clk);
      cycleCount = cycleCount + 1;
      grant = 0;
      hv = host_req && !mAckH;
      lv = loc_req && !mAckL;
      if (reset) begin
        mOwner = 0; mData = '0; mAckH = 1'b0; mAckL = 1'b0;
        mElapsed = 0; mPrefLoc = 1'b0;
      end else begin
        if (mOwner == 0) begin
          if (hv && lv)  grant = mPrefLoc ? 2 : 1;
          else if (hv)   grant = 1;
          else if (lv)   grant = 2;
        end else begin
          ownReq   = (mOwner == 1) ? hv : lv;
          otherReq = (mOwner == 1) ? lv : hv;
          holdDone = (mElapsed >= HOLD - 1) && !lock;
          if (holdDone && otherReq) grant = 3 - mOwner;
          else if (ownReq)          grant = mOwner;
          else if (holdDone)        mOwner = 0;
          else if (!lock)           mElapsed = mElapsed + 1;
        end
        mAckH = (grant == 1);
        mAckL = (grant == 2);
        if (grant != 0) begin
          mOwner   = grant;
          mData    = (grant == 1) ? host_data : loc_data;
          mElapsed = 0;
          mPrefLoc = (grant == 1);
          sbQ.push_back('{who: grant, data: mData});
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, required 0x%08h",
               name, cycleCount, actual, expected);
    end
  endtask

  // Monitor: per-cycle comparison with the model, scoreboard pops on acks,
  // and directed expectations whose cycle has come up.
  initial begin
    sbItem_t  item;
    dirItem_t d;
    forever begin
      @(negedge clk);
      checkOutput("disp_owner", 32'(disp_owner), 32'(mOwner));
      checkOutput("disp_data", disp_data, mData);
      checkOutput("host_ack", 32'(host_ack), 32'(mAckH));
      checkOutput("loc_ack", 32'(loc_ack), 32'(mAckL));
      checkOutput("busy", 32'(busy), 32'(mOwner != 0));
      checkOutput("ack_exclusive", 32'(host_ack & loc_ack), 32'd0);
      if (host_ack || loc_ack) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL sb_unexpected_ack at cycle %0d: got host_ack=%0b loc_ack=%0b, required no ack",
                   cycleCount, host_ack, loc_ack);
        end else begin
          item = sbQ.pop_front();
          checkOutput("sb_who", 32'({loc_ack, host_ack}), 32'(item.who));
          checkOutput("sb_data", disp_data, item.data);
        end
      end
      while (dirQ.size() > 0 && dirQ[0].cyc == cycleCount) begin
        d = dirQ.pop_front();
        checkOutput("dir_owner", 32'(disp_owner), 32'(d.owner));
        checkOutput("dir_host_ack", 32'(host_ack), 32'(d.ha));
        checkOutput("dir_loc_ack", 32'(loc_ack), 32'(d.la));
        checkOutput("dir_data", disp_data, d.data);
      end
      if (testDone && !finalDone) begin
        finalDone = 1'b1;
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
        checkOutput("dir_drained", 32'(dirQ.size()), 32'd0);
      end
    end
  end

  // One cycle of requester behaviour: sample the acks away from the edge,
  // then drop any acknowledged request just after the following edge.
  task automatic stepCycle();
    logic hA, lA;
    @(negedge clk);
    hA = host_ack;
    lA = loc_ack;
    @(posedge clk);
    #1;
    if (hA) host_req = 1'b0;
    if (lA) loc_req = 1'b0;
  endtask

  task automatic applyStimulus(input bit doHost, input logic [31:0] hData,
                               input bit doLoc, input logic [31:0] lData);
    if (doHost) begin host_data = hData; host_req = 1'b1; end
    if (doLoc)  begin loc_data = lData; loc_req = 1'b1; end
  endtask

  task automatic expectAt(input int off, input logic [1:0] owner, input logic ha,
                          input logic la, input logic [31:0] data);
    dirQ.push_back('{cyc: cycleCount + off, owner: owner, ha: ha, la: la, data: data});
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
  endtask

  initial begin
    int lockRun;
    reset = 1'b1; lock = 1'b0;
    host_req = 1'b0; loc_req = 1'b0; host_data = '0; loc_data = '0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    expectAt(0, 2'b00, 1'b0, 1'b0, 32'h0);

    // Single host write, then idle release after the hold.
    applyStimulus(1'b1, 32'h0000_1234, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h0000_1234);
    expectAt(2, 2'b01, 1'b0, 1'b0, 32'h0000_1234);
    expectAt(4, 2'b01, 1'b0, 1'b0, 32'h0000_1234);
    expectAt(5, 2'b00, 1'b0, 1'b0, 32'h0000_1234);
    repeat (6) stepCycle();

    // Simultaneous requests after reset: host first, local after the hold.
    doReset();
    applyStimulus(1'b1, 32'h1111_0001, 1'b1, 32'h2222_0002);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h1111_0001);
    for (int k = 2; k <= 4; k++) expectAt(k, 2'b01, 1'b0, 1'b0, 32'h1111_0001);
    expectAt(5, 2'b10, 1'b0, 1'b1, 32'h2222_0002);
    expectAt(6, 2'b10, 1'b0, 1'b0, 32'h2222_0002);
    repeat (10) stepCycle();

    // Host keeps rewriting while local waits; each write restarts the hold.
    doReset();
    applyStimulus(1'b1, 32'h9, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h9);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h55);
    stepCycle();
    applyStimulus(1'b1, 32'hA, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'hA);
    expectAt(2, 2'b01, 1'b0, 1'b0, 32'hA);
    stepCycle(); stepCycle();
    applyStimulus(1'b1, 32'hB, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'hB);
    expectAt(2, 2'b01, 1'b0, 1'b0, 32'hB);
    stepCycle(); stepCycle();
    applyStimulus(1'b1, 32'hC, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'hC);
    for (int k = 2; k <= 4; k++) expectAt(k, 2'b01, 1'b0, 1'b0, 32'hC);
    expectAt(5, 2'b10, 1'b0, 1'b1, 32'h55);
    repeat (8) stepCycle();

    // Lock for 10 cycles with local waiting; a host write lands mid-lock.
    doReset();
    applyStimulus(1'b1, 32'h77, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h77);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h66);
    lock = 1'b1;
    repeat (3) stepCycle();
    applyStimulus(1'b1, 32'h78, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h78);
    for (int k = 2; k <= 10; k++) expectAt(k, 2'b01, 1'b0, 1'b0, 32'h78);
    expectAt(11, 2'b10, 1'b0, 1'b1, 32'h66);
    repeat (7) stepCycle();
    lock = 1'b0;
    repeat (6) stepCycle();

    // Hold expired with both requesting while host owns: local wins.
    doReset();
    applyStimulus(1'b1, 32'h31, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h31);
    repeat (4) stepCycle();
    applyStimulus(1'b1, 32'h32, 1'b1, 32'h41);
    expectAt(1, 2'b10, 1'b0, 1'b1, 32'h41);
    for (int k = 2; k <= 4; k++) expectAt(k, 2'b10, 1'b0, 1'b0, 32'h41);
    expectAt(5, 2'b01, 1'b1, 1'b0, 32'h32);
    repeat (7) stepCycle();

    // Reset on the edge of a pending grant; the held request wins afterwards.
    doReset();
    applyStimulus(1'b1, 32'h5A, 1'b0, 32'h0);
    expectAt(1, 2'b01, 1'b1, 1'b0, 32'h5A);
    expectAt(5, 2'b00, 1'b0, 1'b0, 32'h5A);
    repeat (5) stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h99);
    reset = 1'b1;
    expectAt(1, 2'b00, 1'b0, 1'b0, 32'h0);
    stepCycle();
    reset = 1'b0;
    expectAt(1, 2'b10, 1'b0, 1'b1, 32'h99);
    repeat (3) stepCycle();

    // Random traffic with lock bursts and rare resets.
    lockRun = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!host_req && $urandom_range(0, 3) == 0)
        applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
      if (!loc_req && $urandom_range(0, 3) == 0)
        applyStimulus(1'b0, 32'h0, 1'b1, $urandom);
      if (lockRun > 0) begin
        lock = 1'b1;
        lockRun--;
      end else begin
        lock = 1'b0;
        if ($urandom_range(0, 40) == 0) lockRun = int'($urandom_range(1, 8));
      end
      reset = ($urandom_range(0, 300) == 0);
      stepCycle();
    end
    reset = 1'b0;
    lock = 1'b0;

    testDone = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
